// File: rtl/coherence_agent.sv
// Cache-side MSI snooping agent: victim writeback, BusRd/BusRdX block fill,
// and snoop responses (hit report, Modified data supply, downgrade/invalidate).
module coherence_agent #(
  parameter int CPUID = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        miss_req,
  input  logic        miss_write,
  input  logic [31:0] miss_addr,
  input  logic        victim_dirty,
  input  logic [31:0] victim_addr,
  input  logic [31:0] victim_data0,
  input  logic [31:0] victim_data1,
  output logic        miss_done,
  output logic [31:0] fill_data0,
  output logic [31:0] fill_data1,
  output logic [1:0]  fill_state,
  output logic [31:0] snp_addr,
  input  logic [1:0]  snp_state,
  input  logic [31:0] snp_data0,
  input  logic [31:0] snp_data1,
  output logic        snp_wen,
  output logic [1:0]  snp_newstate,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait,
  output logic        cctrans,
  output logic        ccwrite,
  input  logic        ccwait,
  input  logic        ccinv,
  input  logic [31:0] ccsnoopaddr
);

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_M = 2'b10;

  typedef enum logic [3:0] {
    IDLE, VWB0, VWB1, REQ, FILL0, FILL1, DONE, SNOOP, SWB0, SWB1
  } state_t;

  state_t      r_state, w_next, r_saved;
  logic [31:0] r_fill0, r_fill1;
  logic [1:0]  r_fill_state;
  logic        w_cap0, w_cap1;
  logic        w_unused_ok;

  assign w_unused_ok = ^{miss_addr[2:0], victim_addr[2:0], ccsnoopaddr[2:0], 1'(CPUID)};

  assign snp_addr   = ccsnoopaddr;
  assign fill_data0 = r_fill0;
  assign fill_data1 = r_fill1;
  assign fill_state = r_fill_state;

  // Word 0 lands from REQ (unless a snoop preempts) or from the post-snoop retry.
  assign w_cap0 = ((r_state == REQ) && !ccwait && !dwait) || ((r_state == FILL0) && !dwait);
  assign w_cap1 = (r_state == FILL1) && !dwait;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_saved      <= IDLE;
      r_fill0      <= '0;
      r_fill1      <= '0;
      r_fill_state <= ST_I;
    end else begin
      if (ccwait && (r_state == IDLE)) r_saved <= IDLE;
      if (ccwait && (r_state == REQ))  r_saved <= FILL0;
      if (w_cap0) r_fill0 <= dload;
      if (w_cap1) begin
        r_fill1      <= dload;
        r_fill_state <= miss_write ? ST_M : ST_S;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (ccwait)        w_next = SNOOP;
        else if (miss_req) w_next = victim_dirty ? VWB0 : REQ;
      end
      VWB0:  if (!dwait) w_next = VWB1;
      VWB1:  if (!dwait) w_next = REQ;
      REQ: begin
        if (ccwait)      w_next = SNOOP;
        else if (!dwait) w_next = FILL1;
      end
      FILL0: if (!dwait) w_next = FILL1;
      FILL1: if (!dwait) w_next = DONE;
      DONE:  w_next = IDLE;
      SNOOP: w_next = (snp_state == ST_M) ? SWB0 : r_saved;
      SWB0:  if (!dwait) w_next = SWB1;
      SWB1:  if (!dwait) w_next = r_saved;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    miss_done    = 1'b0;
    dREN         = 1'b0;
    dWEN         = 1'b0;
    daddr        = '0;
    dstore       = '0;
    cctrans      = 1'b0;
    ccwrite      = 1'b0;
    snp_wen      = 1'b0;
    snp_newstate = ST_I;
    case (r_state)
      VWB0: begin
        dWEN   = 1'b1;
        daddr  = {victim_addr[31:3], 3'b000};
        dstore = victim_data0;
      end
      VWB1: begin
        dWEN   = 1'b1;
        daddr  = {victim_addr[31:3], 3'b100};
        dstore = victim_data1;
      end
      REQ, FILL0: begin
        dREN    = 1'b1;
        cctrans = 1'b1;
        ccwrite = miss_write;
        daddr   = {miss_addr[31:3], 3'b000};
      end
      FILL1: begin
        dREN    = 1'b1;
        cctrans = 1'b1;
        ccwrite = miss_write;
        daddr   = {miss_addr[31:3], 3'b100};
      end
      DONE: miss_done = 1'b1;
      SNOOP: begin
        if (snp_state == ST_M) begin
          cctrans = 1'b1;
          ccwrite = 1'b1;
        end else if (snp_state == ST_S) begin
          cctrans = 1'b1;
          snp_wen = ccinv;
        end
      end
      SWB0: begin
        dWEN    = 1'b1;
        cctrans = 1'b1;
        ccwrite = 1'b1;
        daddr   = {ccsnoopaddr[31:3], 3'b000};
        dstore  = snp_data0;
      end
      SWB1: begin
        dWEN         = 1'b1;
        cctrans      = 1'b1;
        ccwrite      = 1'b1;
        daddr        = {ccsnoopaddr[31:3], 3'b100};
        dstore       = snp_data1;
        snp_wen      = !dwait;
        snp_newstate = ccinv ? ST_I : ST_S;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_coherence_agent.sv
// Scoreboard bench for coherence_agent: stimulus queues expected bus beats,
// snoop responses and fills; a negedge monitor pops and compares them.
module tb_coherence_agent;

  logic        CLK = 1'b0;
  logic        RST;
  logic        miss_req, miss_write, victim_dirty;
  logic [31:0] miss_addr, victim_addr, victim_data0, victim_data1;
  logic        miss_done;
  logic [31:0] fill_data0, fill_data1;
  logic [1:0]  fill_state;
  logic [31:0] snp_addr;
  logic [1:0]  snp_state;
  logic [31:0] snp_data0, snp_data1;
  logic        snp_wen;
  logic [1:0]  snp_newstate;
  logic        dREN, dWEN;
  logic [31:0] daddr, dstore, dload;
  logic        dwait;
  logic        cctrans, ccwrite, ccwait, ccinv;
  logic [31:0] ccsnoopaddr;

  coherence_agent #(.CPUID(0)) dut (
    .CLK(CLK), .RST(RST),
    .miss_req(miss_req), .miss_write(miss_write), .miss_addr(miss_addr),
    .victim_dirty(victim_dirty), .victim_addr(victim_addr),
    .victim_data0(victim_data0), .victim_data1(victim_data1),
    .miss_done(miss_done), .fill_data0(fill_data0), .fill_data1(fill_data1),
    .fill_state(fill_state), .snp_addr(snp_addr), .snp_state(snp_state),
    .snp_data0(snp_data0), .snp_data1(snp_data1), .snp_wen(snp_wen),
    .snp_newstate(snp_newstate), .dREN(dREN), .dWEN(dWEN), .daddr(daddr),
    .dstore(dstore), .dload(dload), .dwait(dwait), .cctrans(cctrans),
    .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr)
  );

  always #5 CLK = ~CLK;

  // Memory returns a recognisable pattern per word address.
  assign dload = daddr ^ 32'hAAAA0100;

  typedef struct packed {
    logic [7:0]  k;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  f;
  } ev_t;

  ev_t expq[$];
  int  expcyc[$];
  int  n_chk = 0;
  int  n_pass = 0;
  int  cyc = 0;
  int  waits = 0;
  int  wcnt = 0;

  initial forever begin
    @(posedge CLK);
    cyc = cyc + 1;
  end

  function automatic ev_t mk(input logic [7:0] k, input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] f);
    ev_t e;
    e.k = k; e.a = a; e.d = d; e.f = f;
    return e;
  endfunction

  task automatic exp_ev(input logic [7:0] k, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] f, input int c);
    expq.push_back(mk(k, a, d, f));
    expcyc.push_back(c);
  endtask

  task automatic compare_ev(input ev_t g, input int gc);
    ev_t e;
    int  c;
    n_chk++;
    if (expq.size() == 0) begin
      $display("FAIL unexpected_%s got a=%h d=%h f=%b cyc=%0d required no event", g.k, g.a, g.d, g.f, gc);
    end else begin
      e = expq.pop_front();
      c = expcyc.pop_front();
      if ((g === e) && ((c == 0) || (c == gc))) n_pass++;
      else $display("FAIL event_%s got %s a=%h d=%h f=%b cyc=%0d required %s a=%h d=%h f=%b cyc=%0d",
                    e.k, g.k, g.a, g.d, g.f, gc, e.k, e.a, e.d, e.f, c);
    end
  endtask

  task automatic check(input string nm, input logic [159:0] got, input logic [159:0] req);
    n_chk++;
    if (got === req) n_pass++;
    else $display("FAIL %s got %h required %h", nm, got, req);
  endtask

  // Monitor: every completed bus word, snoop hit response, fill and snoop write.
  initial forever begin
    @(negedge CLK);
    if (!RST) begin
      if (dREN && !dwait && !ccwait) compare_ev(mk("R", daddr, 32'h0, {cctrans, ccwrite}), cyc);
      if (dWEN && !dwait && !ccwait) compare_ev(mk("W", daddr, dstore, {cctrans, ccwrite}), cyc);
      if (cctrans && !dREN && !dWEN) compare_ev(mk("H", snp_addr, 32'h0, {cctrans, ccwrite}), cyc);
      if (miss_done)                 compare_ev(mk("D", fill_data0, fill_data1, fill_state), cyc);
      if (snp_wen)                   compare_ev(mk("S", snp_addr, 32'h0, snp_newstate), cyc);
    end
  end

  // Bus responder: 'waits' wait cycles before each word completes.
  initial begin
    dwait = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if ((dREN || dWEN) && (wcnt < waits)) begin
        dwait = 1'b1;
        wcnt  = wcnt + 1;
      end else begin
        dwait = 1'b0;
        wcnt  = 0;
      end
    end
  end

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge CLK);
      #1;
      if (miss_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_chk++;
      $display("FAIL done_timeout got no miss_done required miss_done within %0d cycles", budget);
    end
    miss_req = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic snoop(input logic [1:0] st, input logic inv, input logic [31:0] a,
                       input logic [31:0] d0, input logic [31:0] d1, input int ncyc);
    snp_state = st; ccinv = inv; ccsnoopaddr = a; snp_data0 = d0; snp_data1 = d1;
    ccwait = 1'b1;
    @(posedge CLK);
    #1;
    ccwait = 1'b0;
    repeat (ncyc) begin
      @(posedge CLK);
      #1;
    end
    check("snoop_back_idle", {dREN, dWEN, cctrans, snp_wen, miss_done}, 0);
    snp_state = 2'b00; ccinv = 1'b0;
  endtask

  initial begin
    int base;
    RST = 1'b1;
    miss_req = 0; miss_write = 0; miss_addr = 0; victim_dirty = 0; victim_addr = 0;
    victim_data0 = 0; victim_data1 = 0; snp_state = 0; snp_data0 = 0; snp_data1 = 0;
    ccwait = 0; ccinv = 0; ccsnoopaddr = 32'h12345678;
    @(posedge CLK);
    #1;
    check("reset_outputs", {miss_done, dREN, dWEN, cctrans, ccwrite, snp_wen, snp_newstate,
                            fill_state, daddr, dstore, fill_data0, fill_data1}, 0);
    check("reset_snp_addr", snp_addr, 32'h12345678);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // Clean BusRd, no wait states, minimum latency
    waits = 0; miss_addr = 32'h104; miss_write = 0; victim_dirty = 0; miss_req = 1;
    exp_ev("R", 32'h100, 32'h0, 2'b10, 0);
    exp_ev("R", 32'h104, 32'h0, 2'b10, 0);
    exp_ev("D", 32'hAAAA0000, 32'hAAAA0004, 2'b01, cyc + 3);
    wait_done(20);

    // Dirty victim writeback then BusRdX, two wait cycles per word
    waits = 2; miss_addr = 32'h300; miss_write = 1; victim_dirty = 1; victim_addr = 32'h200;
    victim_data0 = 32'h11; victim_data1 = 32'h22; miss_req = 1;
    exp_ev("W", 32'h200, 32'h11, 2'b00, 0);
    exp_ev("W", 32'h204, 32'h22, 2'b00, 0);
    exp_ev("R", 32'h300, 32'h0, 2'b11, 0);
    exp_ev("R", 32'h304, 32'h0, 2'b11, 0);
    exp_ev("D", 32'hAAAA0200, 32'hAAAA0204, 2'b10, 0);
    wait_done(60);
    victim_dirty = 0; miss_write = 0;

    // Snoop hits Modified, invalidating: supply both words, invalidate
    waits = 0;
    exp_ev("H", 32'h444, 32'h0, 2'b11, 0);
    exp_ev("W", 32'h440, 32'h5A0, 2'b11, 0);
    exp_ev("W", 32'h444, 32'h5A4, 2'b11, 0);
    exp_ev("S", 32'h444, 32'h0, 2'b00, 0);
    snoop(2'b10, 1'b1, 32'h444, 32'h5A0, 32'h5A4, 3);

    // Snoop hits Modified, BusRd with one wait per word: downgrade to S
    waits = 1;
    exp_ev("H", 32'h880, 32'h0, 2'b11, 0);
    exp_ev("W", 32'h880, 32'hBEEF0, 2'b11, 0);
    exp_ev("W", 32'h884, 32'hBEEF4, 2'b11, 0);
    exp_ev("S", 32'h880, 32'h0, 2'b01, 0);
    snoop(2'b10, 1'b0, 32'h880, 32'hBEEF0, 32'hBEEF4, 5);
    waits = 0;

    // Snoop hits Shared with invalidate, then a snoop miss
    exp_ev("H", 32'h88C, 32'h0, 2'b10, 0);
    exp_ev("S", 32'h88C, 32'h0, 2'b00, 0);
    snoop(2'b01, 1'b1, 32'h88C, 32'h0, 32'h0, 1);
    snoop(2'b00, 1'b1, 32'h990, 32'h0, 32'h0, 1);

    // Snoop (Shared, no invalidate) preempts REQ; request re-issues
    base = cyc;
    miss_addr = 32'h50C; miss_write = 0; miss_req = 1;
    @(posedge CLK);
    #1;
    ccwait = 1; snp_state = 2'b01; ccinv = 0; ccsnoopaddr = 32'h700;
    exp_ev("H", 32'h700, 32'h0, 2'b10, 0);
    exp_ev("R", 32'h508, 32'h0, 2'b10, 0);
    exp_ev("R", 32'h50C, 32'h0, 2'b10, 0);
    exp_ev("D", 32'hAAAA0408, 32'hAAAA040C, 2'b01, base + 5);
    @(posedge CLK);
    #1;
    ccwait = 0;
    wait_done(20);
    snp_state = 2'b00;

    // Reset in FILL1 abandons the miss
    waits = 2; miss_addr = 32'h600; miss_write = 1; miss_req = 1;
    exp_ev("R", 32'h600, 32'h0, 2'b11, 0);
    repeat (4) begin
      @(posedge CLK);
      #1;
    end
    check("in_fill1", {dREN, cctrans, daddr}, {1'b1, 1'b1, 32'h604});
    RST = 1; miss_req = 0;
    @(posedge CLK);
    #1;
    check("midreset_outputs", {miss_done, dREN, dWEN, cctrans, ccwrite, snp_wen, snp_newstate,
                               fill_state, daddr, dstore, fill_data0, fill_data1}, 0);
    RST = 0;
    repeat (6) begin
      @(posedge CLK);
      #1;
    end
    check("queue_drained", expq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish required finish before 200000");
    $fatal(1);
  end

endmodule
